i2c_master_ctrl: RTL

//  Bit-serial I2C master controller that sequences register write/read transactions to the

---
 rtl/i2c_master_ctrl_pkg.sv | 33 +++
 rtl/i2c_master_ctrl_bit_shifter.sv | 40 ++++
 rtl/i2c_master_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_ctrl_pkg.sv
// Shared definitions for the bit-serial I2C master: state encoding, R/W and ACK levels.
package i2c_master_ctrl_pkg;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;
   localparam logic ACK      = 1'b0;
   localparam logic NACK     = 1'b1;

   typedef enum logic [3:0] {
      StIdle,
      StStart,
      StAddr,
      StAckA,
      StReg,
      StAckR,
      StWdata,
      StAckW,
      StRsH,
      StRsL,
      StAddrR,
      StAckAr,
      StRdata,
      StMnack,
      StStopL,
      StStopH
   } state_e;

   // Slots where the slave owns the line and the master samples ACK/NACK.
   function automatic logic is_ack_slot(state_e s);
      return (s == StAckA) || (s == StAckR) || (s == StAckW) || (s == StAckAr);
   endfunction

endpackage

// File: rtl/i2c_master_ctrl_bit_shifter.sv
// Byte shifter for the I2C master: parallel load, MSB-first shift out, LSB-side sample in,
// with a bit counter flagging the final bit of the byte.
module i2c_master_ctrl_bit_shifter #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              shift,
   input  logic              sample_in,
   output logic              out_bit,
   output logic [DATA_W-1:0] data,
   output logic              last_bit
);

   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [DATA_W-1:0] data_q;
   logic [CNT_W-1:0]  cnt_q;

   // Load restarts the bit count; each shift moves one bit out and one sampled bit in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else if (load) begin
         data_q <= load_data;
         cnt_q  <= '0;
      end else if (shift) begin
         data_q <= {data_q[DATA_W-2:0], sample_in};
         cnt_q  <= cnt_q + 1'b1;
      end
   end

   assign out_bit  = data_q[DATA_W-1];
   assign data     = data_q;
   assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/i2c_master_ctrl.sv
// Bit-serial I2C master: sequences one register write/read per host request on a single
// open-drain sda line, one bit per clk, and reports read data and ACK status.
module i2c_master_ctrl
   import i2c_master_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_dev_addr,
   input  logic [DATA_W-1:0] req_reg_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              busy,
   inout  logic              sda
);

   // The address byte shares the data shifter, so {dev_addr, rw} must fill one byte.
   if (ADDR_W + 1 != DATA_W) begin : g_cfg_check
      $error("i2c_master_ctrl: ADDR_W + 1 must equal DATA_W");
   end

   state_e            state_q, state_d;
   logic              init_q;
   logic              rw_q;
   logic [ADDR_W-1:0] dev_q;
   logic [DATA_W-1:0] reg_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   logic              sda_oe;
   logic              sda_out;
   logic              sda_high;
   logic              accept;

   logic              sh_load;
   logic [DATA_W-1:0] sh_load_data;
   logic              sh_shift;
   logic              sh_out;
   logic [DATA_W-1:0] sh_data;
   logic              sh_last;

   i2c_master_ctrl_bit_shifter #(
      .DATA_W(DATA_W)
   ) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .load     (sh_load),
      .load_data(sh_load_data),
      .shift    (sh_shift),
      .sample_in(sda_high),
      .out_bit  (sh_out),
      .data     (sh_data),
      .last_bit (sh_last)
   );

   assign sda    = sda_oe ? sda_out : 1'bz;
   assign accept = req_valid && req_ready;

   // Anything other than a driven 0 (released, pulled-up or unknown line) reads as 1 / NACK.
   always_comb begin
      sda_high = 1'b1;
      if (sda == 1'b0) sda_high = 1'b0;
   end

   // State register; reset drops any transaction and releases sda at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   // req_ready stays low until the first clock edge after reset is released.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) init_q <= 1'b0;
      else      init_q <= 1'b1;
   end

   // Request capture at accept; result flags built up during the transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rw_q    <= RW_WRITE;
         dev_q   <= '0;
         reg_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         rw_q    <= req_rw;
         dev_q   <= req_dev_addr;
         reg_q   <= req_reg_addr;
         wdata_q <= req_wdata;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (is_ack_slot(state_q) && (sda_high == NACK)) err_q <= 1'b1;
         // Shifter holds the full received byte once RDATA has ended.
         if (state_q == StMnack) rdata_q <= sh_data;
      end
   end

   // Next-state: phase sequencing; any NACK jumps straight to STOP.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = accept ? StStart : StIdle;
         StStopH: state_d = accept ? StStart : StIdle;
         StStart: state_d = StAddr;
         StAddr:  if (sh_last) state_d = StAckA;
         StAckA:  state_d = (sda_high == ACK) ? StReg : StStopL;
         StReg:   if (sh_last) state_d = StAckR;
         StAckR: begin
            if (sda_high == NACK)      state_d = StStopL;
            else if (rw_q == RW_READ)  state_d = StRsH;
            else                       state_d = StWdata;
         end
         StWdata: if (sh_last) state_d = StAckW;
         StAckW:  state_d = StStopL;
         StRsH:   state_d = StRsL;
         StRsL:   state_d = StAddrR;
         StAddrR: if (sh_last) state_d = StAckAr;
         StAckAr: state_d = (sda_high == ACK) ? StRdata : StStopL;
         StRdata: if (sh_last) state_d = StMnack;
         StMnack: state_d = StStopL;
         StStopL: state_d = StStopH;
         default: state_d = StIdle;
      endcase
   end

   // Outputs: sda drive per phase, shifter control, host handshake and response strobe.
   always_comb begin
      sda_oe       = 1'b0;
      sda_out      = 1'b1;
      sh_load      = 1'b0;
      sh_load_data = '0;
      sh_shift     = 1'b0;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      unique case (state_q)
         StIdle: req_ready = init_q;
         // Last cycle of a transaction doubles as the response and next-accept slot.
         StStopH: begin
            req_ready  = init_q;
            resp_valid = 1'b1;
         end
         StStart: begin
            sda_oe       = 1'b1;
            sda_out      = 1'b0;
            sh_load      = 1'b1;
            sh_load_data = {dev_q, RW_WRITE};
         end
         StAddr, StReg, StWdata, StAddrR: begin
            sda_oe   = 1'b1;
            sda_out  = sh_out;
            sh_shift = 1'b1;
         end
         // Loads in ack slots are harmless on NACK since the path goes to STOP.
         StAckA: begin
            sh_load      = 1'b1;
            sh_load_data = reg_q;
         end
         StAckR: begin
            sh_load      = 1'b1;
            sh_load_data = wdata_q;
         end
         StAckW, StRsH: ;
         StRsL: begin
            sda_oe       = 1'b1;
            sda_out      = 1'b0;
            sh_load      = 1'b1;
            sh_load_data = {dev_q, RW_READ};
         end
         StAckAr: begin
            sh_load      = 1'b1;
            sh_load_data = '0;
         end
         StRdata: sh_shift = 1'b1;
         StMnack: begin
            sda_oe  = 1'b1;
            sda_out = NACK;
         end
         StStopL: begin
            sda_oe  = 1'b1;
            sda_out = 1'b0;
         end
         default: ;
      endcase
   end

   assign busy       = (state_q != StIdle) && (state_q != StStopH);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule
